// File: rtl/fp_add_pkg.sv
// fp_add_pkg
//   Shared definitions for the fp_add_requester slice: IEEE-754 single
//   field widths, the response class encodings and a classifier helper.
package fp_add_pkg;

   localparam int FP_SIGN_W = 1;
   localparam int FP_EXP_W  = 8;
   localparam int FP_MANT_W = 23;
   localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MANT_W;

   localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

   localparam logic [1:0] CLS_NORM = 2'b00;   // normal or denormal
   localparam logic [1:0] CLS_ZERO = 2'b01;   // +0 or -0
   localparam logic [1:0] CLS_INF  = 2'b10;
   localparam logic [1:0] CLS_NAN  = 2'b11;

   // Sign does not affect the class, so only exponent and mantissa are used.
   function automatic logic [1:0] fp_class(input logic [FP_W-1:0] x);
      logic [FP_EXP_W-1:0]  e;
      logic [FP_MANT_W-1:0] m;
      logic [1:0]           cls;
      e   = x[FP_MANT_W +: FP_EXP_W];
      m   = x[FP_MANT_W-1:0];
      cls = CLS_NORM;
      if (e == FP_EXP_MAX) begin
         cls = (m != '0) ? CLS_NAN : CLS_INF;
      end else if (e == '0 && m == '0) begin
         cls = CLS_ZERO;
      end
      return cls;
   endfunction

endpackage

// File: rtl/fp_rsp_fifo.sv
// fp_rsp_fifo
//   First-word-fall-through FIFO. data_o/vld_o present the head entry while
//   the FIFO is non-empty; data_o reads as zero when empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i/data_i write one entry (ignored when full without a pop)
//   pop_i         drop the head entry (ignored when empty)
//   data_o/vld_o  head entry and non-empty flag
//   count_o       number of stored entries (0..DEPTH)
module fp_rsp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     vld_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign vld_o   = (count_q != '0);
   assign data_o  = vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/fp_add_requester.sv
// fp_add_requester
//   Issues tagged add commands to a fixed-latency fp32 adder and collects the
//   results, in command order, into a FWFT response FIFO together with the
//   tag, the adder overflow flag and an IEEE-754 class.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_cmd_* / o_cmd_rdy         command ready/valid port (a, b, tag)
//   o_add_a/b, o_add_vld        operands and one-cycle valid to the adder
//   i_add_res/_vld, i_add_ovf   result returning from the adder
//   o_rsp_* / i_rsp_rdy         response ready/valid port (res, tag, ovf, class)
//   o_err_miss                  sticky: a due result did not arrive
//   o_err_unexp                 sticky: a result arrived with nothing due
module fp_add_requester
   import fp_add_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_vld,
   output logic             o_cmd_rdy,
   input  logic [31:0]      i_cmd_a,
   input  logic [31:0]      i_cmd_b,
   input  logic [TAG_W-1:0] i_cmd_tag,
   output logic [31:0]      o_add_a,
   output logic [31:0]      o_add_b,
   output logic             o_add_vld,
   input  logic [31:0]      i_add_res,
   input  logic             i_add_res_vld,
   input  logic             i_add_ovf,
   output logic             o_rsp_vld,
   input  logic             i_rsp_rdy,
   output logic [31:0]      o_rsp_res,
   output logic [TAG_W-1:0] o_rsp_tag,
   output logic             o_rsp_ovf,
   output logic [1:0]       o_rsp_class,
   output logic             o_err_miss,
   output logic             o_err_unexp
);

   localparam int FW  = 32 + TAG_W + 1 + 2;
   localparam int FCW = $clog2(DEPTH) + 1;
   localparam int CW  = $clog2(DEPTH + LAT + 2) + 1;

   logic             add_vld_q, add_vld_d;
   logic [31:0]      add_a_q, add_a_d;
   logic [31:0]      add_b_q, add_b_d;
   logic [TAG_W-1:0] add_tag_q, add_tag_d;
   logic [LAT-1:0]   exp_vld_q, exp_vld_d;
   logic [TAG_W-1:0] exp_tag_q [LAT];
   logic [TAG_W-1:0] exp_tag_d [LAT];
   logic             err_miss_q, err_miss_d;
   logic             err_unexp_q, err_unexp_d;

   logic             cmd_hs;
   logic             due;
   logic             rsp_push, rsp_pop;
   logic [FW-1:0]    rsp_wdata, rsp_rdata;
   logic [FCW-1:0]   rsp_count;
   logic [CW-1:0]    inflight;

   // Credit covers the issue register plus every expectation stage, so a
   // slot is held from accept until its result is in the FIFO (or missed).
   always_comb begin
      inflight = CW'(add_vld_q);
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + CW'(exp_vld_q[i]);
      end
   end

   assign o_cmd_rdy = !rst && ((CW'(rsp_count) + inflight) < CW'(DEPTH));
   assign cmd_hs    = i_cmd_vld && o_cmd_rdy;
   assign due       = exp_vld_q[LAT-1];
   assign rsp_push  = due && i_add_res_vld;
   assign rsp_pop   = o_rsp_vld && i_rsp_rdy;
   assign rsp_wdata = {i_add_res, exp_tag_q[LAT-1], i_add_ovf, fp_class(i_add_res)};

   always_comb begin
      add_vld_d   = cmd_hs;
      add_a_d     = cmd_hs ? i_cmd_a   : add_a_q;
      add_b_d     = cmd_hs ? i_cmd_b   : add_b_q;
      add_tag_d   = cmd_hs ? i_cmd_tag : add_tag_q;
      exp_vld_d   = exp_vld_q;
      exp_tag_d   = exp_tag_q;
      exp_vld_d[0] = add_vld_q;
      exp_tag_d[0] = add_tag_q;
      for (int i = 1; i < LAT; i++) begin
         exp_vld_d[i] = exp_vld_q[i-1];
         exp_tag_d[i] = exp_tag_q[i-1];
      end
      err_miss_d  = err_miss_q  || (due && !i_add_res_vld);
      err_unexp_d = err_unexp_q || (!due && i_add_res_vld);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_vld_q   <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_tag_q   <= '0;
         exp_vld_q   <= '0;
         for (int i = 0; i < LAT; i++) exp_tag_q[i] <= '0;
         err_miss_q  <= 1'b0;
         err_unexp_q <= 1'b0;
      end else begin
         add_vld_q   <= add_vld_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_tag_q   <= add_tag_d;
         exp_vld_q   <= exp_vld_d;
         exp_tag_q   <= exp_tag_d;
         err_miss_q  <= err_miss_d;
         err_unexp_q <= err_unexp_d;
      end
   end

   fp_rsp_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_push),
      .data_i  (rsp_wdata),
      .pop_i   (rsp_pop),
      .data_o  (rsp_rdata),
      .vld_o   (o_rsp_vld),
      .count_o (rsp_count)
   );

   assign {o_rsp_res, o_rsp_tag, o_rsp_ovf, o_rsp_class} = rsp_rdata;

   assign o_add_vld   = add_vld_q;
   assign o_add_a     = add_a_q;
   assign o_add_b     = add_b_q;
   assign o_err_miss  = err_miss_q;
   assign o_err_unexp = err_unexp_q;

endmodule

// File: tb/tb_fp_add_requester.sv
// tb_fp_add_requester
//   Directed bench for fp_add_requester with a loopback adder model whose
//   results come from a hand-computed lookup table.
module tb_fp_add_requester;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_cmd_vld;
   logic             o_cmd_rdy;
   logic [31:0]      i_cmd_a, i_cmd_b;
   logic [TAG_W-1:0] i_cmd_tag;
   logic [31:0]      o_add_a, o_add_b;
   logic             o_add_vld;
   logic [31:0]      i_add_res;
   logic             i_add_res_vld;
   logic             i_add_ovf;
   logic             o_rsp_vld;
   logic             i_rsp_rdy;
   logic [31:0]      o_rsp_res;
   logic [TAG_W-1:0] o_rsp_tag;
   logic             o_rsp_ovf;
   logic [1:0]       o_rsp_class;
   logic             o_err_miss, o_err_unexp;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fp_add_requester #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_cmd_vld     (i_cmd_vld),
      .o_cmd_rdy     (o_cmd_rdy),
      .i_cmd_a       (i_cmd_a),
      .i_cmd_b       (i_cmd_b),
      .i_cmd_tag     (i_cmd_tag),
      .o_add_a       (o_add_a),
      .o_add_b       (o_add_b),
      .o_add_vld     (o_add_vld),
      .i_add_res     (i_add_res),
      .i_add_res_vld (i_add_res_vld),
      .i_add_ovf     (i_add_ovf),
      .o_rsp_vld     (o_rsp_vld),
      .i_rsp_rdy     (i_rsp_rdy),
      .o_rsp_res     (o_rsp_res),
      .o_rsp_tag     (o_rsp_tag),
      .o_rsp_ovf     (o_rsp_ovf),
      .o_rsp_class   (o_rsp_class),
      .o_err_miss    (o_err_miss),
      .o_err_unexp   (o_err_unexp)
   );

   // ---------------- adder model ----------------
   function automatic logic [32:0] mdl_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      case ({a, b})
         {32'h40600000, 32'hC0100000}: r = {1'b0, 32'h3FA00000}; //  3.5 + -2.25
         {32'h3F800000, 32'h40000000}: r = {1'b0, 32'h40400000}; //  1.0 + 2.0
         {32'h3F000000, 32'h3E800000}: r = {1'b0, 32'h3F400000}; //  0.5 + 0.25
         {32'h7F800000, 32'hFF800000}: r = {1'b0, 32'h7FC00000}; //  inf + -inf
         {32'h80000000, 32'h00000000}: r = {1'b0, 32'h00000000}; // -0 + +0
         {32'h7F7FFFFF, 32'h7F7FFFFF}: r = {1'b1, 32'h7F800000}; //  max + max
         default:                      r = {1'b0, a};            //  x + 0
      endcase
      return r;
   endfunction

   logic [LAT-1:0] mdl_vld_q;
   logic [31:0]    mdl_res_q [LAT];
   logic           mdl_ovf_q [LAT];
   bit             suppress = 1'b0;
   bit             inj_vld  = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            mdl_res_q[i] <= '0;
            mdl_ovf_q[i] <= 1'b0;
         end
      end else begin
         mdl_vld_q[0] <= o_add_vld && !suppress;
         {mdl_ovf_q[0], mdl_res_q[0]} <= mdl_add(o_add_a, o_add_b);
         for (int i = 1; i < LAT; i++) begin
            mdl_vld_q[i] <= mdl_vld_q[i-1];
            mdl_res_q[i] <= mdl_res_q[i-1];
            mdl_ovf_q[i] <= mdl_ovf_q[i-1];
         end
      end
   end

   assign i_add_res_vld = mdl_vld_q[LAT-1] | inj_vld;
   assign i_add_res     = inj_vld ? 32'h3F800000 : mdl_res_q[LAT-1];
   assign i_add_ovf     = mdl_ovf_q[LAT-1] & mdl_vld_q[LAT-1];

   // The FIFO must never be pushed while full with no pop in the same cycle.
   always @(negedge clk) begin
      if (!rst && dut.rsp_push && !dut.rsp_pop && int'(dut.rsp_count) >= DEPTH) begin
         miscompares++;
         $display("FAIL fifo_overflow: count=%0d with push, limit %0d", dut.rsp_count, DEPTH);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Returns #1 after the accepting clock edge.
   task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      int n = 0;
      @(negedge clk);
      i_cmd_vld = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_tag = tag;
      while (!o_cmd_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!o_cmd_rdy) begin
         miscompares++;
         $display("FAIL cmd_accept_timeout: o_cmd_rdy=%b required 1 (tag %0d)", o_cmd_rdy, tag);
         i_cmd_vld = 1'b0;
      end else begin
         @(posedge clk); #1;
         i_cmd_vld = 1'b0;
      end
   endtask

   // Waits (bounded) for a head entry and pops it; caller holds i_rsp_rdy=1.
   task automatic wait_rsp(output logic [31:0] res, output logic [TAG_W-1:0] tag,
                           output logic ovf, output logic [1:0] cls, output bit got);
      int n = 0;
      got = 1'b0; res = '0; tag = '0; ovf = 1'b0; cls = '0;
      @(negedge clk);
      while (!o_rsp_vld && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (o_rsp_vld) begin
         got = 1'b1;
         res = o_rsp_res; tag = o_rsp_tag; ovf = o_rsp_ovf; cls = o_rsp_class;
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (o_cmd_rdy !== 1'b0 || o_add_vld !== 1'b0 || o_rsp_vld !== 1'b0 || o_rsp_res !== 32'h0 ||
          o_err_miss !== 1'b0 || o_err_unexp !== 1'b0 || o_add_a !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdy=%b add_vld=%b rsp_vld=%b res=%h miss=%b unexp=%b add_a=%h, required all 0",
                  o_cmd_rdy, o_add_vld, o_rsp_vld, o_rsp_res, o_err_miss, o_err_unexp, o_add_a);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (o_cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_rdy: o_cmd_rdy=%b required 1", o_cmd_rdy);
      end
   endtask

   task automatic test_single();
      int cyc = 0;
      send_cmd(32'h40600000, 32'hC0100000, 4'd3);
      vectors++;
      if (o_add_vld !== 1'b1 || o_add_a !== 32'h40600000 || o_add_b !== 32'hC0100000) begin
         miscompares++;
         $display("FAIL issue_single: vld=%b a=%h b=%h required 1 40600000 c0100000", o_add_vld, o_add_a, o_add_b);
      end
      while (o_rsp_vld !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            vectors++;
            if (o_add_vld !== 1'b0 || o_add_a !== 32'h40600000) begin
               miscompares++;
               $display("FAIL add_vld_pulse: vld=%b a=%h required 0 40600000", o_add_vld, o_add_a);
            end
         end
      end
      // Visible in cycle accept+LAT+2, i.e. after LAT+1 further edges.
      vectors++;
      if (cyc != LAT + 1) begin
         miscompares++;
         $display("FAIL latency: %0d edges after accept, required %0d", cyc, LAT + 1);
      end
      vectors++;
      if (o_rsp_res !== 32'h3FA00000 || o_rsp_tag !== 4'd3 || o_rsp_class !== 2'b00 || o_rsp_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL single_rsp: res=%h tag=%0d cls=%b ovf=%b required 3fa00000 3 00 0",
                  o_rsp_res, o_rsp_tag, o_rsp_class, o_rsp_ovf);
      end
      @(posedge clk); #1;
      vectors++;
      if (o_rsp_vld !== 1'b0 || o_err_miss !== 1'b0 || o_err_unexp !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pop: rsp_vld=%b miss=%b unexp=%b required 0 0 0", o_rsp_vld, o_err_miss, o_err_unexp);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic [TAG_W-1:0] t; logic ov; logic [1:0] c; bit got;
      @(negedge clk);
      i_cmd_vld = 1'b1; i_cmd_a = 32'h3F800000; i_cmd_b = 32'h40000000; i_cmd_tag = 4'd1;
      @(posedge clk); #1;
      i_cmd_a = 32'h3F000000; i_cmd_b = 32'h3E800000; i_cmd_tag = 4'd2;
      vectors++;
      if (o_add_vld !== 1'b1 || o_add_a !== 32'h3F800000) begin
         miscompares++;
         $display("FAIL b2b_first_issue: vld=%b a=%h required 1 3f800000", o_add_vld, o_add_a);
      end
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      vectors++;
      if (o_add_vld !== 1'b1 || o_add_a !== 32'h3F000000 || o_add_b !== 32'h3E800000) begin
         miscompares++;
         $display("FAIL b2b_second_issue: vld=%b a=%h b=%h required 1 3f000000 3e800000", o_add_vld, o_add_a, o_add_b);
      end
      @(posedge clk); #1;
      vectors++;
      if (o_add_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_vld_drop: vld=%b required 0", o_add_vld);
      end
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h40400000 || t !== 4'd1) begin
         miscompares++;
         $display("FAIL b2b_rsp0: got=%0d res=%h tag=%0d required 1 40400000 1", got, r, t);
      end
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h3F400000 || t !== 4'd2 || c !== 2'b00) begin
         miscompares++;
         $display("FAIL b2b_rsp1: got=%0d res=%h tag=%0d cls=%b required 1 3f400000 2 00", got, r, t, c);
      end
   endtask

   task automatic test_classes();
      logic [31:0] r; logic [TAG_W-1:0] t; logic ov; logic [1:0] c; bit got;
      send_cmd(32'h7F800000, 32'hFF800000, 4'd4);
      send_cmd(32'h80000000, 32'h00000000, 4'd5);
      send_cmd(32'h7F7FFFFF, 32'h7F7FFFFF, 4'd6);
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h7FC00000 || t !== 4'd4 || c !== 2'b11 || ov !== 1'b0) begin
         miscompares++;
         $display("FAIL class_nan: got=%0d res=%h tag=%0d cls=%b ovf=%b required 1 7fc00000 4 11 0", got, r, t, c, ov);
      end
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h00000000 || t !== 4'd5 || c !== 2'b01) begin
         miscompares++;
         $display("FAIL class_zero: got=%0d res=%h tag=%0d cls=%b required 1 00000000 5 01", got, r, t, c);
      end
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h7F800000 || t !== 4'd6 || c !== 2'b10 || ov !== 1'b1) begin
         miscompares++;
         $display("FAIL class_inf_ovf: got=%0d res=%h tag=%0d cls=%b ovf=%b required 1 7f800000 6 10 1", got, r, t, c, ov);
      end
   endtask

   task automatic test_credit();
      logic [31:0] av [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      logic [31:0] r; logic [TAG_W-1:0] t; logic ov; logic [1:0] c; bit got;
      bit seen = 1'b0;
      i_rsp_rdy = 1'b0;
      for (int k = 0; k < 4; k++) send_cmd(av[k], 32'h0, TAG_W'(k + 8));
      vectors++;
      if (o_cmd_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL credit_full_rdy: o_cmd_rdy=%b required 0", o_cmd_rdy);
      end
      @(negedge clk);
      i_cmd_vld = 1'b1; i_cmd_a = av[4]; i_cmd_b = 32'h0; i_cmd_tag = 4'd12;
      repeat (8) begin
         @(posedge clk); #1;
         if (o_add_vld) seen = 1'b1;
      end
      vectors++;
      if (seen || o_cmd_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL credit_stall: issued=%0d rdy=%b required 0 0", seen, o_cmd_rdy);
      end
      vectors++;
      if (o_rsp_vld !== 1'b1 || o_rsp_tag !== 4'd8 || o_rsp_res !== av[0]) begin
         miscompares++;
         $display("FAIL credit_head: vld=%b tag=%0d res=%h required 1 8 %h", o_rsp_vld, o_rsp_tag, o_rsp_res, av[0]);
      end
      i_rsp_rdy = 1'b1;
      @(posedge clk); #1;
      i_rsp_rdy = 1'b0;
      vectors++;
      if (o_cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL credit_restore: o_cmd_rdy=%b required 1", o_cmd_rdy);
      end
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      vectors++;
      if (o_add_vld !== 1'b1 || o_add_a !== av[4]) begin
         miscompares++;
         $display("FAIL credit_fifth_issue: vld=%b a=%h required 1 %h", o_add_vld, o_add_a, av[4]);
      end
      i_rsp_rdy = 1'b1;
      for (int k = 1; k < 5; k++) begin
         wait_rsp(r, t, ov, c, got);
         vectors++;
         if (!got || r !== av[k] || t !== TAG_W'(k + 8)) begin
            miscompares++;
            $display("FAIL credit_drain_%0d: got=%0d res=%h tag=%0d required 1 %h %0d", k, got, r, t, av[k], k + 8);
         end
      end
   endtask

   task automatic test_miss_unexp();
      logic [31:0] r; logic [TAG_W-1:0] t; logic ov; logic [1:0] c; bit got;
      suppress = 1'b1;
      send_cmd(32'h3F800000, 32'h40000000, 4'd5);
      @(posedge clk); #1;
      suppress = 1'b0;
      send_cmd(32'h3F000000, 32'h3E800000, 4'd6);
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h3F400000 || t !== 4'd6) begin
         miscompares++;
         $display("FAIL miss_next_rsp: got=%0d res=%h tag=%0d required 1 3f400000 6", got, r, t);
      end
      vectors++;
      if (o_err_miss !== 1'b1 || o_err_unexp !== 1'b0) begin
         miscompares++;
         $display("FAIL err_miss: miss=%b unexp=%b required 1 0", o_err_miss, o_err_unexp);
      end
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (o_rsp_vld !== 1'b0) begin
         miscompares++;
         $display("FAIL miss_no_extra: rsp_vld=%b required 0", o_rsp_vld);
      end
      @(negedge clk);
      inj_vld = 1'b1;
      @(negedge clk);
      inj_vld = 1'b0;
      vectors++;
      if (o_err_unexp !== 1'b1 || o_rsp_vld !== 1'b0 || o_err_miss !== 1'b1) begin
         miscompares++;
         $display("FAIL err_unexp: unexp=%b rsp_vld=%b miss=%b required 1 0 1", o_err_unexp, o_rsp_vld, o_err_miss);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] r; logic [TAG_W-1:0] t; logic ov; logic [1:0] c; bit got;
      i_rsp_rdy = 1'b0;
      send_cmd(32'h40600000, 32'hC0100000, 4'd7);
      repeat (LAT + 2) @(posedge clk);
      #1;
      vectors++;
      if (o_rsp_vld !== 1'b1 || o_rsp_tag !== 4'd7) begin
         miscompares++;
         $display("FAIL midop_queued: rsp_vld=%b tag=%0d required 1 7", o_rsp_vld, o_rsp_tag);
      end
      @(negedge clk);
      i_cmd_vld = 1'b1; i_cmd_a = 32'h3F800000; i_cmd_b = 32'h40000000; i_cmd_tag = 4'd1;
      @(posedge clk); #1;
      i_cmd_a = 32'h3F000000; i_cmd_b = 32'h3E800000; i_cmd_tag = 4'd2;
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if (o_cmd_rdy !== 1'b0 || o_add_vld !== 1'b0 || o_rsp_vld !== 1'b0 || o_rsp_res !== 32'h0 ||
          o_rsp_tag !== 4'd0 || o_err_miss !== 1'b0 || o_err_unexp !== 1'b0 || o_add_a !== 32'h0) begin
         miscompares++;
         $display("FAIL midop_reset: rdy=%b add_vld=%b rsp_vld=%b res=%h tag=%0d miss=%b unexp=%b add_a=%h, required all 0",
                  o_cmd_rdy, o_add_vld, o_rsp_vld, o_rsp_res, o_rsp_tag, o_err_miss, o_err_unexp, o_add_a);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      i_rsp_rdy = 1'b1;
      repeat (LAT + 3) @(posedge clk);
      #1;
      vectors++;
      if (o_rsp_vld !== 1'b0 || o_err_miss !== 1'b0 || o_err_unexp !== 1'b0 || o_cmd_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_after: rsp_vld=%b miss=%b unexp=%b rdy=%b required 0 0 0 1",
                  o_rsp_vld, o_err_miss, o_err_unexp, o_cmd_rdy);
      end
      send_cmd(32'h3F800000, 32'h40000000, 4'd9);
      wait_rsp(r, t, ov, c, got);
      vectors++;
      if (!got || r !== 32'h40400000 || t !== 4'd9 || c !== 2'b00) begin
         miscompares++;
         $display("FAIL midop_new_cmd: got=%0d res=%h tag=%0d cls=%b required 1 40400000 9 00", got, r, t, c);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      i_cmd_vld = 1'b0;
      i_cmd_a   = '0;
      i_cmd_b   = '0;
      i_cmd_tag = '0;
      i_rsp_rdy = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_classes();
      test_credit();
      test_miss_unexp();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fp_add_requester.md
Name: fp_add_requester

Overview:
Requester/collector at the other end of the adder_32bit operand/result interface (i_a/i_b/i_vld in, o_res/o_res_vld/overflow out).
- Accepts tagged add commands over a ready/valid port and issues them to the adder as single-cycle valid pulses.
- Tracks in-flight operations through a fixed-latency expectation pipeline and captures returning results, with overflow and an IEEE-754 class, into a response FIFO.
- Issue is credit-gated, so results are never dropped for lack of space.

Parameters:
LAT, 2, adder latency in cycles from o_add_vld high to i_add_res_vld high (>=1)
DEPTH, 4, response FIFO entries (power of 2, >=2)
TAG_W, 4, command tag width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_cmd_vld  input  1  command valid
o_cmd_rdy  output  1  command ready
i_cmd_a  input  32  operand A (IEEE-754 single)
i_cmd_b  input  32  operand B
i_cmd_tag  input  TAG_W  command tag, returned with the response
o_add_a  output  32  to adder i_a
o_add_b  output  32  to adder i_b
o_add_vld  output  1  to adder i_vld, one-cycle pulse per operation
i_add_res  input  32  from adder o_res
i_add_res_vld  input  1  from adder o_res_vld
i_add_ovf  input  1  from adder overflow
o_rsp_vld  output  1  response valid
i_rsp_rdy  input  1  response ready
o_rsp_res  output  32  result
o_rsp_tag  output  TAG_W  tag
o_rsp_ovf  output  1  overflow flag captured with result
o_rsp_class  output  2  00 normal/denormal, 01 zero, 10 infinity, 11 NaN
o_err_miss  output  1  sticky: expected result did not arrive
o_err_unexp  output  1  sticky: result arrived with nothing expected

Behaviour:
- Reset (async): all outputs 0, including o_cmd_rdy; FIFO empty; expectation pipeline cleared; error flags cleared. Reset mid-operation discards all in-flight ops and queued responses. Results arriving after reset deassertion with nothing expected set o_err_unexp.
- Credit: inflight = o_add_vld + number of valid expectation stages. o_cmd_rdy = !rst && (fifo_count + inflight < DEPTH). Registered and combinational computation are both acceptable, but the limit must never be exceeded.
- Issue: handshake (i_cmd_vld && o_cmd_rdy) at edge N registers o_add_a/o_add_b/tag. o_add_vld is high for exactly cycle N+1, then low unless another handshake occurred at edge N+1. Back-to-back issue at one per cycle is allowed.
- o_add_a/o_add_b hold their last value when o_add_vld is low.
- Expectation pipeline: LAT stages of {valid, tag}. Stage 0 loads {o_add_vld, tag} each edge and stages shift each cycle. The last stage valid means a result is due this cycle.
- Capture, when the last stage is valid:
  - if i_add_res_vld = 1: push {i_add_res, tag, i_add_ovf, class} into the FIFO;
  - else: set o_err_miss and release the slot.
- i_add_res_vld = 1 with the last stage invalid: set o_err_unexp and discard the result.
- Class from i_add_res:
  - exp == FF, mant != 0: 11 (NaN)
  - exp == FF, mant == 0: 10 (infinity)
  - exp == 0, mant == 0: 01 (zero, either sign)
  - else: 00
- FIFO is first-word-fall-through. o_rsp_* reflect the head entry. Pop on o_rsp_vld && i_rsp_rdy. Simultaneous push and pop keeps the count unchanged.
- Full and overflow cannot occur under credit gating; the verification engineer must assert this. Pointers wrap modulo DEPTH.
- Error flags are sticky until reset.
- Response order equals command order.

Decomposition:
- Package fp_add_pkg:
  - FP_EXP_MAX = 8'hFF
  - class encodings CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN
  - fp32 field slice widths (sign 1, exp 8, mant 23)
  - function fp_class(logic [31:0]) returning 2 bits
- One sub-module: fp_rsp_fifo, a parameterised FWFT FIFO (width, depth) with count output.

Test Plan:
- Loopback adder model, LAT=2: cmd 0x40600000 + 0xC0100000, tag 3 -> 0x3FA00000, tag 3, class 00, ovf 0, exactly LAT+2 cycles after accept.
- Back-to-back 1.0+2.0 (tag 1) and 0.5+0.25 (tag 2) -> 0x40400000 then 0x3F400000, in order, o_add_vld high two consecutive cycles.
- 0x7F800000 + 0xFF800000, model returns 0x7FC00000 -> class 11. 0x80000000 + 0x00000000, model returns 0x00000000 -> class 01.
- DEPTH=4, i_rsp_rdy=0: o_cmd_rdy falls after 4 accepts and a 5th command stalls. Raising i_rsp_rdy drains all 4 in order, one pop restores o_cmd_rdy, and the 5th issues.
- Model suppresses one o_res_vld -> o_err_miss=1 and no response for that tag, later ops still correct. Inject a spurious i_add_res_vld while idle -> o_err_unexp=1.
- Assert rst with 2 ops in flight and 1 queued -> all outputs 0 and o_rsp_vld=0 after reset; new command afterwards completes normally.
